// File: rtl/flex_counter_bank_pkg.sv
// flex_counter_bank_pkg: shared direction type and default sizing for the counter bank
package flex_counter_bank_pkg;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
    localparam int DEF_SIZE = 8;
    localparam int DEF_NUM_CH = 4;
endpackage

// File: rtl/flex_bank_channel.sv
// flex_bank_channel: one up/down counter with terminal flags and a wrap strobe for cascading
module flex_bank_channel
    import flex_counter_bank_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            enable,
    input  dir_t            dir,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic [SIZE-1:0] rollover_val,
    output logic [SIZE-1:0] count,
    output logic            rollover_flag,
    output logic            underflow_flag,
    output logic            wrap
);
    logic            at_term;
    logic [SIZE-1:0] next_count;

    // next count by priority clear > load > enable > hold; wrap marks a terminal step
    always_comb begin
        at_term = (dir == DIR_DOWN) ? (count <= SIZE'(1)) : (count >= rollover_val);
        wrap = enable & ~clear & ~load & at_term;
        next_count = clear ? '0 :
                     load ? load_val :
                     !enable ? count :
                     (dir == DIR_DOWN) ? (at_term ? rollover_val : count - SIZE'(1)) :
                     (at_term ? SIZE'(1) : count + SIZE'(1));
    end

    // register count and the flags derived from the value being loaded into it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
            rollover_flag <= 1'b0;
            underflow_flag <= 1'b0;
        end else begin
            count <= next_count;
            rollover_flag <= !clear && dir == DIR_UP && rollover_val != '0 && next_count == rollover_val;
            underflow_flag <= !clear && dir == DIR_DOWN && next_count == SIZE'(1);
        end
    end
endmodule

// File: rtl/flex_counter_bank.sv
// flex_counter_bank: bank of NUM_CH counters, optionally cascaded; FLEX_COUNTER_BANK_SNAPSHOT_EN adds a count snapshot
module flex_counter_bank
    import flex_counter_bank_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CASCADE = 0
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_CH-1:0]          clear,
    input  logic [NUM_CH-1:0]          count_enable,
    input  logic [NUM_CH-1:0]          count_down,
    input  logic [NUM_CH-1:0]          load,
    input  logic [NUM_CH-1:0][SIZE-1:0] load_val,
    input  logic [NUM_CH-1:0][SIZE-1:0] rollover_val,
`ifdef FLEX_COUNTER_BANK_SNAPSHOT_EN
    input  logic                       snap,
    output logic [NUM_CH-1:0][SIZE-1:0] snap_count,
    output logic                       snap_valid,
`endif
    output logic [NUM_CH-1:0][SIZE-1:0] count_out,
    output logic [NUM_CH-1:0]          rollover_flag,
    output logic [NUM_CH-1:0]          underflow_flag
);
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] en;
    logic              unused_wrap;

    assign unused_wrap = ^wrap;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (CASCADE != 0 && i > 0) begin : g_casc
            assign en[i] = count_enable[i] & wrap[i-1];
        end else begin : g_ind
            assign en[i] = count_enable[i];
        end
        flex_bank_channel #(.SIZE(SIZE)) u_ch (
            .clk(clk),
            .n_rst(n_rst),
            .clear(clear[i]),
            .enable(en[i]),
            .dir(dir_t'(count_down[i])),
            .load(load[i]),
            .load_val(load_val[i]),
            .rollover_val(rollover_val[i]),
            .count(count_out[i]),
            .rollover_flag(rollover_flag[i]),
            .underflow_flag(underflow_flag[i]),
            .wrap(wrap[i])
        );
    end

`ifdef FLEX_COUNTER_BANK_SNAPSHOT_EN
    // capture all counts on snap and pulse snap_valid for one cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            snap_count <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_count <= snap ? count_out : snap_count;
            snap_valid <= snap;
        end
    end
`endif
endmodule

// File: doc/flex_counter_bank.md
FLEX_COUNTER_BANK -- requirements
Module: flex_counter_bank

Interface
REQ-001 SHALL have parameter SIZE, default 8, counter width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent counter channels.
REQ-003 SHALL have parameter CASCADE, default 0; when 1, channel i>0 advances only on channel i-1 wrap.
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear  input  NUM_CH  per-channel synchronous clear.
REQ-007 SHALL have port count_enable  input  NUM_CH  per-channel count strobe.
REQ-008 SHALL have port count_down  input  NUM_CH  per-channel direction; 0 = up, 1 = down.
REQ-009 SHALL have port load  input  NUM_CH  per-channel synchronous load strobe.
REQ-010 SHALL have port load_val  input  NUM_CH x SIZE  per-channel load value.
REQ-011 SHALL have port rollover_val  input  NUM_CH x SIZE  per-channel terminal value.
REQ-012 SHALL have port count_out  output  NUM_CH x SIZE  per-channel registered count.
REQ-013 SHALL have port rollover_flag  output  NUM_CH  registered up-terminal flag.
REQ-014 SHALL have port underflow_flag  output  NUM_CH  registered down-terminal flag.

Function
REQ-015 Per channel, next-state priority SHALL be: clear > load > effective enable > hold.
REQ-016 clear SHALL set count to 0 and force both flags to 0 next cycle, regardless of other inputs.
REQ-017 load SHALL set count to load_val unmodified, including values 0 or > rollover_val.
REQ-018 Up enable: count >= rollover_val -> 1; else count+1.
REQ-019 Down enable: count <= 1 -> rollover_val; else count-1.
REQ-020 rollover_flag SHALL register (next count == rollover_val) when not clearing and count_down=0; else 0; it stays high while count holds at rollover_val.
REQ-021 underflow_flag SHALL register (next count == 1) when not clearing and count_down=1; else 0.
REQ-022 Latency: count and flags SHALL update on the clock edge after the strobe; no combinational input-to-output path.
REQ-023 Wrap event for a channel SHALL be: effective enable, no clear/load, and count at terminal (up: >= rollover_val; down: <= 1).
REQ-024 CASCADE=1: effective enable of channel i>0 SHALL be count_enable[i] AND wrap event of channel i-1 in the same cycle; channel 0 uses count_enable[0].
REQ-025 CASCADE=0: effective enable SHALL equal count_enable[i]; channels fully independent.
REQ-026 rollover_val=0: up counting SHALL go to 1 on every enable and never raise rollover_flag; down counting SHALL go to 0.

Reset
REQ-027 n_rst low SHALL immediately clear all count_out to 0 and all flags to 0, including mid-count.
REQ-028 First enabled up-count after reset SHALL yield 1.

Configuration
REQ-029 Macro FLEX_COUNTER_BANK_SNAPSHOT_EN defined SHALL add input snap (1) and outputs snap_count (NUM_CH x SIZE), snap_valid (1).
REQ-030 With it, snap high SHALL capture every current count_out into snap_count next edge and pulse snap_valid high one cycle; snap_count holds otherwise; reset clears both.
REQ-031 Without it, those ports and registers SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package flex_counter_bank_pkg SHALL hold direction typedef (DIR_UP, DIR_DOWN) and default SIZE/NUM_CH constants.
REQ-033 Sub-module flex_bank_channel SHALL implement one channel (count, flags, wrap output), instantiated NUM_CH times by generate.

Verification (SIZE=4, NUM_CH=2)
REQ-034 Up, rollover_val=5, enable 6 cycles from reset -> count 1,2,3,4,5,1; rollover_flag high only while count=5.
REQ-035 Load 3, then down enable 4 cycles, rollover_val=5 -> 2,1,5,4; underflow_flag high only while count=1.
REQ-036 clear, load (val 7) and enable same cycle at count 4 -> count 0, both flags 0.
REQ-037 CASCADE=1, ch0 rollover 3, ch1 rollover 2, both enabled 7 cycles -> ch1 goes 0->1 on ch0 3->1, then 1->2 on next ch0 wrap.
REQ-038 Load 9 with rollover_val=5, up enable -> 1; n_rst low mid-count -> count 0 and flags 0 without clock edge.
REQ-039 SNAPSHOT_EN defined, counts 2 and 4, snap pulse -> snap_count {4,2}, snap_valid one-cycle pulse next edge.
